rf_bypass: RTL and testbench
============================

Name: rf_bypass

Overview:
- Parametrised successor to the integer register file.
- Decodes the writeback source from the retiring instruction's opcode.
- Reads are synchronous, one-cycle latency, with configurable write-to-read bypass, RV32E/RV32I depth, and a read-hold mode for pipeline stalls.
- Sits between decode (rs_instr) and writeback (rd_instr) in the core, and replaces the single-mode register file with its external SRAM.

Parameters:
- XLEN, 32, datapath width in bits.
- NUM_REGS, 32, architectural register count; legal values 16 (RV32E) or 32 (RV32I).
- BYPASS, 1, 1 = same-cycle write forwarded to read outputs; 0 = read returns the pre-write value.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- rs_instr  in  [31:2]  decode-stage instruction; rs1 = [19:15], rs2 = [24:20].
- rd_instr  in  [31:2]  writeback-stage instruction; opcode = [6:2], rd = [11:7].
- rd_valid  in  1  writeback instruction valid; gates all writes.
- ieu_result  in  XLEN  ALU result.
- lsu_data  in  XLEN  load data.
- inc_pc  in  XLEN  PC+4 link value.
- hold  in  1  stall; freezes captured read addresses.
- rs1_data  out  XLEN  registered rs1 value.
- rs2_data  out  XLEN  registered rs2 value.
- illegal_reg  out  1  registered flag: last captured read, or the current write, used an index >= NUM_REGS.

Behaviour:
- Reset (rst_n=0 at posedge):
  - All registers, rs1_data, rs2_data and illegal_reg become 0.
  - Captured addresses become 0.
  - No write occurs that cycle, regardless of rd_valid.
- Writeback decode (combinational, opcode = rd_instr[6:2]):
  - LOAD 00000 writes lsu_data.
  - JALR 11001 and JAL 11011 write inc_pc.
  - OP_IMM 00100, OP 01100, AUIPC 00101 and LUI 01101 write ieu_result.
  - All other opcodes (STORE, BRANCH, SYSTEM, ...) perform no write.
- Write enable: we = rd_valid & decoded write & rd != 0 & rd < NUM_REGS. The write commits at the posedge.
- x0 is hardwired to 0 and never stored.
- Read latency is 1 cycle. When hold=0, the posedge captures rs1/rs2 addresses from rs_instr and drives rs1_data/rs2_data with the array value.
- Bypass: when BYPASS=1 and we=1 and rd equals a captured address in the same cycle, that output takes the write data. When BYPASS=0 it takes the old array value.
- Read of x0 or of an index >= NUM_REGS returns 0.
- Hold (hold=1):
  - Captured addresses are unchanged and rs_instr is ignored.
  - Writes still commit.
  - If we=1 and rd matches a held address, the corresponding output updates to the write data at that posedge, in both BYPASS modes, so the value seen on hold release is never stale.
  - Otherwise the outputs are stable.
- Simultaneous rs1 == rs2 == rd: both outputs update identically.
- illegal_reg:
  - Set at a posedge if a newly captured rs1/rs2 index >= NUM_REGS, or if rd_valid & decoded write & rd >= NUM_REGS.
  - Cleared otherwise.
  - Always 0 when NUM_REGS=32.
- Reset asserted during hold: reset wins; outputs 0 and hold state is discarded.
- Storage is an inferred flop array of (NUM_REGS-1) x XLEN; no external SRAM instance.

Test Plan:
- Reset, then read x1..x31 with no writes -> every rs1_data/rs2_data = 0 one cycle after address; illegal_reg = 0.
- Write sweep: OP to x5 with ieu_result=0xDEADBEEF, next cycle read rs1=x5 -> rs1_data=0xDEADBEEF. Then LOAD to x5 with lsu_data=0x12345678 -> 0x12345678. Then JAL to x1 with inc_pc=0x104 -> 0x104. Then STORE opcode 01000 with rd field=5 -> x5 unchanged.
- Same-cycle write/read of x7, old value 0x11, new value 0x22 -> BYPASS=1 gives rs1_data=0x22; BYPASS=0 gives 0x11, and 0x22 on the following read.
- x0 write (LUI, rd=0, ieu_result=0xFFFFFFFF) then read x0 -> 0. rd_valid=0 with OP to x3 -> x3 unchanged.
- hold=1 with rs1=x4 captured (0xA), rs_instr changed to x9, OP writes x4=0xB -> rs1_data=0xB and remains so. On hold=0, rs_instr=x9 is captured next cycle.
- NUM_REGS=16: read x20 -> rs1_data=0, illegal_reg=1. OP write to x17 -> no array change, illegal_reg=1. rst_n=0 mid-hold -> all outputs 0 next cycle.

Source files
------------

// File: rtl/rf_bypass_if.sv
// Bundle of decode/writeback/read signals between the core pipeline and rf_bypass.
// master = core pipeline side, slave = register file side.
interface rf_bypass_if #(
  parameter int XLEN = 32
);
  logic [31:2]     rs_instr;
  logic [31:2]     rd_instr;
  logic            rd_valid;
  logic [XLEN-1:0] ieu_result;
  logic [XLEN-1:0] lsu_data;
  logic [XLEN-1:0] inc_pc;
  logic            hold;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            illegal_reg;

  modport master (
    output rs_instr, rd_instr, rd_valid, ieu_result, lsu_data, inc_pc, hold,
    input  rs1_data, rs2_data, illegal_reg
  );

  modport slave (
    input  rs_instr, rd_instr, rd_valid, ieu_result, lsu_data, inc_pc, hold,
    output rs1_data, rs2_data, illegal_reg
  );
endinterface

// File: rtl/rf_bypass.sv
// Integer register file with one-cycle synchronous reads, optional write-to-read
// forwarding, RV32E/RV32I depth and a stall-hold mode for the read addresses.
module rf_bypass #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int BYPASS   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  rf_bypass_if.slave bus
);
  localparam logic [5:0] NREG_W = 6'(NUM_REGS);
  localparam logic       BYP_EN = (BYPASS != 0);

  logic [XLEN-1:0] regs_r [1:NUM_REGS-1];
  logic [4:0]      raddr1_r, raddr2_r;
  logic [XLEN-1:0] rs1_data_r, rs2_data_r;
  logic            illegal_reg_r;

  logic [4:0]      opcode_s, rd_s, cap1_s, cap2_s;
  logic            wr_dec_s, we_s, hit1_s, hit2_s, illegal_next_s;
  logic [XLEN-1:0] wdata_s, rdata1_s, rdata2_s, next1_s, next2_s;

  function automatic logic idx_illegal(input logic [4:0] idx);
    return ({1'b0, idx} >= NREG_W);
  endfunction

  assign opcode_s = bus.rd_instr[6:2];
  assign rd_s     = bus.rd_instr[11:7];
  assign we_s     = bus.rd_valid && wr_dec_s && (rd_s != 5'd0) && !idx_illegal(rd_s);
  // While stalled the held addresses stay live so a matching write refreshes the output.
  assign cap1_s   = bus.hold ? raddr1_r : bus.rs_instr[19:15];
  assign cap2_s   = bus.hold ? raddr2_r : bus.rs_instr[24:20];
  assign hit1_s   = we_s && (rd_s == cap1_s);
  assign hit2_s   = we_s && (rd_s == cap2_s);

  // Writeback source selection from the retiring opcode
  always_comb begin
    wr_dec_s = 1'b0;
    wdata_s  = {XLEN{1'b0}};
    case (opcode_s)
      5'b00000: begin
        wr_dec_s = 1'b1;
        wdata_s  = bus.lsu_data;
      end
      5'b11001, 5'b11011: begin
        wr_dec_s = 1'b1;
        wdata_s  = bus.inc_pc;
      end
      5'b00100, 5'b01100, 5'b00101, 5'b01101: begin
        wr_dec_s = 1'b1;
        wdata_s  = bus.ieu_result;
      end
      default: begin
        wr_dec_s = 1'b0;
        wdata_s  = {XLEN{1'b0}};
      end
    endcase
  end

  // Array read mux; x0 and out-of-range indices fall through to zero
  always_comb begin
    rdata1_s = {XLEN{1'b0}};
    rdata2_s = {XLEN{1'b0}};
    for (int i = 1; i < NUM_REGS; i++) begin
      rdata1_s = (cap1_s == 5'(i)) ? regs_r[i] : rdata1_s;
      rdata2_s = (cap2_s == 5'(i)) ? regs_r[i] : rdata2_s;
    end
  end

  // Next output values: forwarding, hold refresh, or plain array read
  always_comb begin
    if (hit1_s && (bus.hold || BYP_EN)) begin
      next1_s = wdata_s;
    end else if (bus.hold) begin
      next1_s = rs1_data_r;
    end else begin
      next1_s = rdata1_s;
    end
    if (hit2_s && (bus.hold || BYP_EN)) begin
      next2_s = wdata_s;
    end else if (bus.hold) begin
      next2_s = rs2_data_r;
    end else begin
      next2_s = rdata2_s;
    end
    illegal_next_s = (!bus.hold && (idx_illegal(cap1_s) || idx_illegal(cap2_s)))
                   || (bus.rd_valid && wr_dec_s && idx_illegal(rd_s));
  end

  // Register array storage, x0 not stored
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (we_s && (rd_s == 5'(i))) begin
          regs_r[i] <= wdata_s;
        end
      end
    end
  end

  // Captured read addresses and registered read outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      raddr1_r      <= 5'd0;
      raddr2_r      <= 5'd0;
      rs1_data_r    <= {XLEN{1'b0}};
      rs2_data_r    <= {XLEN{1'b0}};
      illegal_reg_r <= 1'b0;
    end else begin
      raddr1_r      <= cap1_s;
      raddr2_r      <= cap2_s;
      rs1_data_r    <= next1_s;
      rs2_data_r    <= next2_s;
      illegal_reg_r <= illegal_next_s;
    end
  end

  assign bus.rs1_data    = rs1_data_r;
  assign bus.rs2_data    = rs2_data_r;
  assign bus.illegal_reg = illegal_reg_r;
endmodule

// File: tb/tb_rf_bypass.sv
// Directed bench for rf_bypass: three instances (RV32I bypass, RV32I no-bypass,
// RV32E bypass) share one stimulus stream and are checked against hand-computed values.
module tb_rf_bypass;
  logic        clk;
  logic        rst_n;
  logic [31:2] rs_instr, rd_instr;
  logic        rd_valid, hold;
  logic [31:0] ieu_result, lsu_data, inc_pc;
  int          n_cmp = 0;
  int          n_err = 0;

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_OP    = 5'b01100;
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_JAL   = 5'b11011;
  localparam logic [4:0] OP_STORE = 5'b01000;

  rf_bypass_if #(.XLEN(32)) bus_a ();
  rf_bypass_if #(.XLEN(32)) bus_b ();
  rf_bypass_if #(.XLEN(32)) bus_c ();

  assign bus_a.rs_instr = rs_instr;   assign bus_b.rs_instr = rs_instr;   assign bus_c.rs_instr = rs_instr;
  assign bus_a.rd_instr = rd_instr;   assign bus_b.rd_instr = rd_instr;   assign bus_c.rd_instr = rd_instr;
  assign bus_a.rd_valid = rd_valid;   assign bus_b.rd_valid = rd_valid;   assign bus_c.rd_valid = rd_valid;
  assign bus_a.ieu_result = ieu_result; assign bus_b.ieu_result = ieu_result; assign bus_c.ieu_result = ieu_result;
  assign bus_a.lsu_data = lsu_data;   assign bus_b.lsu_data = lsu_data;   assign bus_c.lsu_data = lsu_data;
  assign bus_a.inc_pc = inc_pc;       assign bus_b.inc_pc = inc_pc;       assign bus_c.inc_pc = inc_pc;
  assign bus_a.hold = hold;           assign bus_b.hold = hold;           assign bus_c.hold = hold;

  rf_bypass #(.XLEN(32), .NUM_REGS(32), .BYPASS(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  rf_bypass #(.XLEN(32), .NUM_REGS(32), .BYPASS(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  rf_bypass #(.XLEN(32), .NUM_REGS(16), .BYPASS(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:2] rsi(input logic [4:0] a, input logic [4:0] b);
    logic [31:2] v;
    v = '0;
    v[19:15] = a;
    v[24:20] = b;
    return v;
  endfunction

  function automatic logic [31:2] wbi(input logic [4:0] op, input logic [4:0] rd);
    logic [31:2] v;
    v = '0;
    v[6:2]  = op;
    v[11:7] = rd;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] val);
    rd_instr = wbi(op, rd); rd_valid = 1'b1;
    ieu_result = val; lsu_data = val; inc_pc = val;
    rs_instr = rsi(5'd0, 5'd0);
    step();
    rd_valid = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    rd_valid = 1'b0;
    rs_instr = rsi(a, b);
    step();
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0;
    rs_instr = rsi(5'd5, 5'd5); rd_instr = wbi(OP_OP, 5'd5); rd_valid = 1'b1;
    ieu_result = 32'h5555_5555; lsu_data = 32'h0; inc_pc = 32'h0;
    @(negedge clk);
    step();
    chk("reset_rs1", bus_a.rs1_data, 32'h0);
    chk("reset_rs2", bus_a.rs2_data, 32'h0);
    chk("reset_ill", {31'b0, bus_a.illegal_reg}, 32'h0);
    chk("reset_ill_e", {31'b0, bus_c.illegal_reg}, 32'h0);
    rst_n = 1'b1;

    // all registers read zero after reset; write attempted during reset must not land
    for (int i = 1; i < 32; i++) begin
      rd(5'(i), 5'(32 - i));
      chk("empty_rs1", bus_a.rs1_data, 32'h0);
      chk("empty_rs2", bus_a.rs2_data, 32'h0);
      chk("empty_ill", {31'b0, bus_a.illegal_reg}, 32'h0);
    end

    wr(OP_OP, 5'd5, 32'hDEAD_BEEF);
    rd(5'd5, 5'd0);
    chk("op_x5", bus_a.rs1_data, 32'hDEAD_BEEF);
    chk("op_x5_e", bus_c.rs1_data, 32'hDEAD_BEEF);
    rd_instr = wbi(OP_LOAD, 5'd5); rd_valid = 1'b1;
    ieu_result = 32'h0BAD_0BAD; lsu_data = 32'h1234_5678; inc_pc = 32'h0BAD_0BAD;
    rs_instr = rsi(5'd0, 5'd0);
    step();
    rd(5'd5, 5'd0);
    chk("load_x5", bus_a.rs1_data, 32'h1234_5678);
    rd_instr = wbi(OP_JAL, 5'd1); rd_valid = 1'b1;
    ieu_result = 32'h0BAD_0BAD; lsu_data = 32'h0BAD_0BAD; inc_pc = 32'h0000_0104;
    step();
    rd(5'd1, 5'd5);
    chk("jal_x1", bus_a.rs1_data, 32'h0000_0104);
    chk("jal_x1_e", bus_c.rs1_data, 32'h0000_0104);
    chk("x5_keep", bus_a.rs2_data, 32'h1234_5678);
    wr(OP_STORE, 5'd5, 32'hFFFF_0000);
    rd(5'd5, 5'd0);
    chk("store_nowr", bus_a.rs1_data, 32'h1234_5678);

    // same-cycle write and read of x7
    wr(OP_OP, 5'd7, 32'h11);
    rd_instr = wbi(OP_OP, 5'd7); rd_valid = 1'b1; ieu_result = 32'h22;
    rs_instr = rsi(5'd7, 5'd7);
    step();
    chk("byp1_rs1", bus_a.rs1_data, 32'h22);
    chk("byp1_rs2", bus_a.rs2_data, 32'h22);
    chk("byp0_rs1", bus_b.rs1_data, 32'h11);
    chk("byp0_rs2", bus_b.rs2_data, 32'h11);
    rd(5'd7, 5'd0);
    chk("byp0_next", bus_b.rs1_data, 32'h22);

    // x0 stays zero, including forwarding of an x0 write
    rd_instr = wbi(OP_LUI, 5'd0); rd_valid = 1'b1; ieu_result = 32'hFFFF_FFFF;
    rs_instr = rsi(5'd0, 5'd0);
    step();
    chk("x0_byp", bus_a.rs1_data, 32'h0);
    rd(5'd0, 5'd0);
    chk("x0_read", bus_a.rs1_data, 32'h0);
    wr(OP_OP, 5'd3, 32'h3);
    rd_instr = wbi(OP_OP, 5'd3); rd_valid = 1'b0; ieu_result = 32'h33;
    step();
    rd(5'd3, 5'd0);
    chk("novalid_x3", bus_a.rs1_data, 32'h3);

    // hold: captured x4 refreshed by write, x9 ignored until release
    wr(OP_OP, 5'd9, 32'h99);
    wr(OP_OP, 5'd4, 32'hA);
    rd(5'd4, 5'd0);
    chk("hold_pre", bus_a.rs1_data, 32'hA);
    hold = 1'b1; rs_instr = rsi(5'd9, 5'd0);
    rd_instr = wbi(OP_OP, 5'd4); rd_valid = 1'b1; ieu_result = 32'hB;
    step();
    chk("hold_wr_a", bus_a.rs1_data, 32'hB);
    chk("hold_wr_b", bus_b.rs1_data, 32'hB);
    rd_valid = 1'b0;
    step();
    chk("hold_stable", bus_a.rs1_data, 32'hB);
    hold = 1'b0;
    step();
    chk("hold_rel", bus_a.rs1_data, 32'h99);

    // RV32E depth checks
    rd(5'd20, 5'd0);
    chk("e_x20_rs1", bus_c.rs1_data, 32'h0);
    chk("e_x20_ill", {31'b0, bus_c.illegal_reg}, 32'h1);
    chk("i_x20_ill", {31'b0, bus_a.illegal_reg}, 32'h0);
    wr(OP_OP, 5'd17, 32'h17);
    chk("e_wr17_ill", {31'b0, bus_c.illegal_reg}, 32'h1);
    chk("i_wr17_ill", {31'b0, bus_a.illegal_reg}, 32'h0);
    rd(5'd17, 5'd1);
    chk("i_x17", bus_a.rs1_data, 32'h17);
    chk("e_x17", bus_c.rs1_data, 32'h0);
    chk("e_x1_keep", bus_c.rs2_data, 32'h0000_0104);
    rd(5'd1, 5'd2);
    chk("e_ill_clr", {31'b0, bus_c.illegal_reg}, 32'h0);

    // reset during hold
    rd(5'd5, 5'd5);
    chk("pre_rst", bus_a.rs1_data, 32'h1234_5678);
    hold = 1'b1;
    step();
    rst_n = 1'b0;
    step();
    chk("rst_hold_a1", bus_a.rs1_data, 32'h0);
    chk("rst_hold_a2", bus_a.rs2_data, 32'h0);
    chk("rst_hold_c1", bus_c.rs1_data, 32'h0);
    rst_n = 1'b1; hold = 1'b0;
    rd(5'd5, 5'd1);
    chk("post_rst_x5", bus_a.rs1_data, 32'h0);
    chk("post_rst_x1", bus_a.rs2_data, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
